// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: 32-cycle shift-add multiply and restoring
// divide on operand magnitudes, followed by one sign-fix cycle that writes HI/LO.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t state, state_next;

    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   operand_b;
    logic [WIDTH-1:0]   dividend_orig;
    logic               is_div;
    logic               neg_res;
    logic               neg_rem;
    logic               div_zero;

    logic               accept;
    logic               signed_op;
    logic               sign_a;
    logic               sign_b;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     sub_diff;
    logic [2*WIDTH-1:0] mul_next;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   quotient;
    logic [WIDTH-1:0]   remainder;

    assign accept    = (state == IDLE) && start;
    assign signed_op = ~op[0];
    assign sign_a    = signed_op & rs_data[WIDTH-1];
    assign sign_b    = signed_op & rt_data[WIDTH-1];
    assign mag_a     = sign_a ? (~rs_data + 1'b1) : rs_data;
    assign mag_b     = sign_b ? (~rt_data + 1'b1) : rt_data;

    // One iteration of each algorithm; acc holds {partial, multiplier/dividend bits}.
    always_comb begin
        add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, operand_b};
        sub_diff = acc[2*WIDTH-1:WIDTH-1] - {1'b0, operand_b};
        mul_next = acc[0] ? {add_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};
        div_next = sub_diff[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                   : {sub_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end

    always_comb begin
        product   = neg_res ? (~acc + 1'b1) : acc;
        quotient  = neg_res ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
        remainder = neg_rem ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept && !op[2]) state_next = RUN;
            RUN:     if (cancel) state_next = IDLE;
                     else if (count == '0) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count         <= '0;
            acc           <= '0;
            operand_b     <= '0;
            dividend_orig <= '0;
            is_div        <= 1'b0;
            neg_res       <= 1'b0;
            neg_rem       <= 1'b0;
            div_zero      <= 1'b0;
            done          <= 1'b0;
            hi            <= '0;
            lo            <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        case (op)
                            3'b000, 3'b001, 3'b010, 3'b011: begin
                                count         <= CW'(WIDTH - 1);
                                acc           <= {{WIDTH{1'b0}}, mag_a};
                                operand_b     <= mag_b;
                                dividend_orig <= rs_data;
                                is_div        <= op[1];
                                neg_res       <= sign_a ^ sign_b;
                                neg_rem       <= sign_a;
                                div_zero      <= (rt_data == '0);
                            end
                            3'b100:  hi <= rs_data;
                            3'b101:  lo <= rs_data;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    if (!cancel) begin
                        acc   <= is_div ? div_next : mul_next;
                        count <= count - 1'b1;
                    end
                end
                FIX: begin
                    if (!cancel) begin
                        done <= 1'b1;
                        if (!is_div) begin
                            {hi, lo} <= product;
                        end else if (div_zero) begin
                            lo <= '1;
                            hi <= dividend_orig;
                        end else begin
                            lo <= quotient;
                            hi <= remainder;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
